// File: rtl/keypad_pkg.sv
// keypad_pkg: shared key code type, debounce FSM states and default debounce length
package keypad_pkg;
  typedef logic [3:0] key_code_t;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} debounce_state_t;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 120000;
endpackage

// File: rtl/keypad_debouncer_timer.sv
// debounce_timer: saturating stability counter; clear_i restarts, en_i advances, done_o at DEBOUNCE_CYCLES-1
module debounce_timer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic done_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign done_o = cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1);
  always_comb cnt_d = clear_i ? '0 : (en_i && !done_o) ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/keypad_debouncer.sv
// keypad_debouncer: debounces scanner key level/code into one key_valid strobe per press with one-key lockout
module keypad_debouncer
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_pressed,
  input  logic [3:0] raw_code,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  debounce_state_t state_q, state_d;
  key_code_t cand_q, cand_d, key_code_q, key_code_d;
  logic key_valid_q, key_valid_d, key_held_q, key_held_d;
  logic clear, en, done, match;
  debounce_timer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_timer (
    .clk(clk), .reset(reset), .clear_i(clear), .en_i(en), .done_o(done)
  );
  always_comb begin
    match = raw_pressed && raw_code == cand_q;
    state_d = state_q;
    cand_d = cand_q;
    key_code_d = key_code_q;
    key_valid_d = 1'b0;
    clear = 1'b0;
    en = 1'b0;
    case (state_q)
      IDLE: if (raw_pressed) begin
        cand_d = raw_code;
        clear = 1'b1;
        state_d = PRESS_WAIT;
      end
      PRESS_WAIT:
        if (!match) state_d = IDLE;
        else if (done) begin
          state_d = HELD;
          key_code_d = cand_q;
          key_valid_d = 1'b1;
        end else en = 1'b1;
      // any code while held is locked out; only a release matters
      HELD: if (!raw_pressed) begin
        clear = 1'b1;
        state_d = RELEASE_WAIT;
      end
      RELEASE_WAIT:
        if (raw_pressed) state_d = HELD;
        else if (done) state_d = IDLE;
        else en = 1'b1;
      default: state_d = IDLE;
    endcase
    key_held_d = state_d == HELD || state_d == RELEASE_WAIT;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cand_q <= '0;
      key_code_q <= '0;
      key_valid_q <= 1'b0;
      key_held_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q <= cand_d;
      key_code_q <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q <= key_held_d;
    end
  assign key_code = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held = key_held_q;
endmodule

// File: tb/tb_keypad_debouncer.sv
// tb_keypad_debouncer: scoreboard bench with a sample-counting reference model for keypad_debouncer
module tb_keypad_debouncer;
  localparam int D = 4;
  typedef struct {int edge_n; logic [3:0] code;} exp_t;
  logic clk = 1'b0, reset = 1'b1, raw_pressed = 1'b0;
  logic [3:0] raw_code = '0, key_code;
  logic key_valid, key_held;
  int checks = 0, errors = 0, strobes = 0, edge_cnt = 0;
  exp_t q[$];
  bit m_held = 0;
  int m_run = 0, m_rel = 0;
  logic [3:0] m_cand = '0, m_code = '0;
  keypad_debouncer #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .raw_pressed(raw_pressed), .raw_code(raw_code),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask
  function automatic void model_reset();
    m_held = 0;
    m_run = 0;
    m_rel = 0;
    m_cand = '0;
    m_code = '0;
    q.delete();
  endfunction
  // a press is accepted after D+1 consecutive samples of one code; the sample that breaks
  // a run is consumed, so a new run starts on the following sample. While held, only
  // D+1 consecutive released samples end the key.
  function automatic void model_step(bit p, logic [3:0] c);
    if (!m_held) begin
      if (m_run == 0) begin
        if (p) begin
          m_cand = c;
          m_run = 1;
        end
      end else if (p && c == m_cand) begin
        m_run++;
        if (m_run == D + 1) begin
          m_held = 1;
          m_run = 0;
          m_rel = 0;
          m_code = m_cand;
          q.push_back('{edge_cnt + 1, m_cand});
        end
      end else m_run = 0;
    end else if (p) m_rel = 0;
    else begin
      m_rel++;
      if (m_rel == D + 1) begin
        m_held = 0;
        m_rel = 0;
      end
    end
  endfunction
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      chk("key_held", key_held, m_held);
      chk("key_code", key_code, m_code);
      if (key_valid) begin
        strobes++;
        if (q.size() == 0) chk("unexpected_strobe", key_code, 32'hDEAD);
        else begin
          chk("strobe_cycle", edge_cnt, q[0].edge_n);
          chk("strobe_code", key_code, q[0].code);
          void'(q.pop_front());
        end
      end else if (q.size() != 0 && q[0].edge_n <= edge_cnt) begin
        chk("missing_strobe", edge_cnt, q[0].edge_n);
        void'(q.pop_front());
      end
    end
  end
  task automatic cyc(bit p, logic [3:0] c);
    @(negedge clk);
    reset = 1'b0;
    raw_pressed = p;
    raw_code = c;
    model_step(p, c);
  endtask
  task automatic rep(int n, bit p, logic [3:0] c);
    for (int i = 0; i < n; i++) cyc(p, c);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    chk("rst_key_code", key_code, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_held", key_held, 0);
    model_reset();
  endtask
  initial begin
    int s0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("init_key_code", key_code, 0);
    chk("init_key_held", key_held, 0);
    chk("init_key_valid", key_valid, 0);
    rep(3, 0, 0);
    s0 = strobes;
    rep(2, 1, 6); rep(1, 0, 0); rep(2, 1, 6); rep(8, 0, 0);
    chk("bounce_strobes", strobes - s0, 0);
    chk("bounce_code", key_code, 0);
    s0 = strobes;
    rep(10, 1, 5); rep(8, 0, 0);
    chk("clean_strobes", strobes - s0, 1);
    s0 = strobes;
    rep(2, 1, 3); rep(8, 1, 7); rep(8, 0, 0);
    chk("codechg_strobes", strobes - s0, 1);
    chk("codechg_code", key_code, 7);
    s0 = strobes;
    rep(7, 1, 4'hA); rep(2, 0, 0); rep(3, 1, 4'hA); rep(8, 0, 0);
    chk("relbounce_strobes", strobes - s0, 1);
    chk("relbounce_code", key_code, 4'hA);
    s0 = strobes;
    rep(7, 1, 1); rep(6, 1, 9);
    chk("lockout_strobes", strobes - s0, 1);
    chk("lockout_code", key_code, 1);
    rep(8, 0, 0); rep(7, 1, 9); rep(8, 0, 0);
    chk("lockout_fresh_strobes", strobes - s0, 2);
    chk("lockout_fresh_code", key_code, 9);
    rep(7, 1, 2);
    do_reset();
    s0 = strobes;
    rep(7, 1, 2); rep(8, 0, 0);
    chk("reset_held_strobes", strobes - s0, 1);
    chk("reset_held_code", key_code, 2);
    s0 = strobes;
    rep(3, 1, 4);
    do_reset();
    rep(8, 0, 0);
    chk("reset_press_strobes", strobes - s0, 0);
    for (int s = 0; s < 150; s++) begin
      int n = $urandom_range(1, 8);
      logic [3:0] c = 4'($urandom_range(0, 15));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 9) == 0) c = 4'($urandom_range(0, 15));
        cyc(1, c);
      end
      rep($urandom_range(1, 8), 0, 0);
    end
    rep(10, 0, 0);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
